// File: rtl/reset_ctrl.sv
// PLL-lock driven reset sequencer for the 6502 core: synchronises LOCK, filters it,
// holds the core in reset with cpu_ce running, then releases; records lock loss.
module reset_ctrl #(
  parameter int LOCK_FILTER = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int CE_DIV      = 50
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       locked,
  input  logic       clear_lost,
  output logic       cpu_reset_n,
  output logic       cpu_ce,
  output logic       lock_lost,
  output logic [1:0] state_o
);

  localparam int FW = $clog2(LOCK_FILTER + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int DW = $clog2(CE_DIV + 1);

  localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILTER - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CE_DIV - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t          state_q;
  logic            sync1_q;
  logic            lk_s_q;
  logic [FW-1:0]   filt_q;
  logic [HW-1:0]   hold_q;
  logic [DW-1:0]   div_q;
  logic [DW-1:0]   div_d;
  logic            div_last;
  logic            cpu_reset_n_q;
  logic            cpu_ce_q;
  logic            lock_lost_q;

  // cpu_ce is registered from div_last, so it is high in the cycle after the wrap count
  always_comb begin
    div_last = (div_q == DIV_LAST);
    div_d    = div_last ? '0 : div_q + DW'(1);
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= WAIT_LOCK;
      sync1_q       <= 1'b0;
      lk_s_q        <= 1'b0;
      filt_q        <= '0;
      hold_q        <= '0;
      div_q         <= '0;
      cpu_reset_n_q <= 1'b0;
      cpu_ce_q      <= 1'b0;
      lock_lost_q   <= 1'b0;
    end else begin
      sync1_q <= locked;
      lk_s_q  <= sync1_q;

      // A lock-loss set later in this block overrides the clear
      if (clear_lost) lock_lost_q <= 1'b0;

      case (state_q)
        WAIT_LOCK: begin
          cpu_reset_n_q <= 1'b0;
          cpu_ce_q      <= 1'b0;
          div_q         <= '0;
          hold_q        <= '0;
          if (!lk_s_q) begin
            filt_q <= '0;
          end else if (filt_q == FILT_LAST) begin
            state_q <= HOLD;
            filt_q  <= '0;
          end else begin
            filt_q <= filt_q + FW'(1);
          end
        end

        HOLD: begin
          cpu_reset_n_q <= 1'b0;
          div_q         <= div_d;
          cpu_ce_q      <= div_last;
          if (!lk_s_q) begin
            state_q  <= WAIT_LOCK;
            hold_q   <= '0;
            div_q    <= '0;
            cpu_ce_q <= 1'b0;
          end else if (hold_q == HOLD_LAST) begin
            state_q       <= RUN;
            hold_q        <= '0;
            cpu_reset_n_q <= 1'b1;
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end

        RUN: begin
          cpu_reset_n_q <= 1'b1;
          div_q         <= div_d;
          cpu_ce_q      <= div_last;
          if (!lk_s_q) begin
            state_q       <= WAIT_LOCK;
            cpu_reset_n_q <= 1'b0;
            cpu_ce_q      <= 1'b0;
            div_q         <= '0;
            filt_q        <= '0;
            lock_lost_q   <= 1'b1;
          end
        end

        default: begin
          state_q       <= WAIT_LOCK;
          cpu_reset_n_q <= 1'b0;
          cpu_ce_q      <= 1'b0;
          div_q         <= '0;
          filt_q        <= '0;
          hold_q        <= '0;
        end
      endcase
    end
  end

  assign cpu_reset_n = cpu_reset_n_q;
  assign cpu_ce      = cpu_ce_q;
  assign lock_lost   = lock_lost_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_reset_ctrl.sv
// Directed bench for reset_ctrl: lock-up timeline table plus hand-written
// sequences for glitches, lock loss, clear/set collision, async reset and CE_DIV=1.
module tb_reset_ctrl;

  logic       clk;
  logic       reset_n;
  logic       locked;
  logic       clear_lost;
  logic       cpu_reset_n;
  logic       cpu_ce;
  logic       lock_lost;
  logic [1:0] state_o;

  logic       cpu_reset_n1;
  logic       cpu_ce1;
  logic       lock_lost1;
  logic [1:0] state_o1;

  int tests = 0;
  int fails = 0;

  reset_ctrl #(.LOCK_FILTER(4), .HOLD_CYCLES(16), .CE_DIV(50)) dut (
    .clock_in    (clk),
    .reset_n     (reset_n),
    .locked      (locked),
    .clear_lost  (clear_lost),
    .cpu_reset_n (cpu_reset_n),
    .cpu_ce      (cpu_ce),
    .lock_lost   (lock_lost),
    .state_o     (state_o)
  );

  reset_ctrl #(.LOCK_FILTER(4), .HOLD_CYCLES(16), .CE_DIV(1)) dut_ce1 (
    .clock_in    (clk),
    .reset_n     (reset_n),
    .locked      (locked),
    .clear_lost  (clear_lost),
    .cpu_reset_n (cpu_reset_n1),
    .cpu_ce      (cpu_ce1),
    .lock_lost   (lock_lost1),
    .state_o     (state_o1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       lk;
    logic       clr;
    logic       rst;
    logic       ce;
    logic       lost;
    logic [1:0] st;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic rst, input logic ce,
                         input logic lost, input logic [1:0] st);
    chk({nm, ".cpu_reset_n"}, 32'(cpu_reset_n), 32'(rst));
    chk({nm, ".cpu_ce"},      32'(cpu_ce),      32'(ce));
    chk({nm, ".lock_lost"},   32'(lock_lost),   32'(lost));
    chk({nm, ".state"},       32'(state_o),     32'(st));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Edge numbers count from the first edge sampling locked=1 after reset release
    vt[0]  = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};  // edge 1
    vt[1]  = '{4,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};  // edge 5
    vt[2]  = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};  // edge 6: HOLD
    vt[3]  = '{15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};  // edge 21
    vt[4]  = '{1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2};  // edge 22: RUN
    vt[5]  = '{33, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2};  // edge 55
    vt[6]  = '{1,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2};  // edge 56: first ce
    vt[7]  = '{1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2};  // edge 57
    vt[8]  = '{48, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2};  // edge 105
    vt[9]  = '{1,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2};  // edge 106
    vt[10] = '{1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2};  // edge 107

    reset_n    = 1'b0;
    locked     = 1'b1;
    clear_lost = 1'b0;

    step(1);
    chk_all("rst_a", 1'b0, 1'b0, 1'b0, 2'd0);
    step(3);
    chk_all("rst_b", 1'b0, 1'b0, 1'b0, 2'd0);
    chk("rst_b.ce1", 32'(cpu_ce1), 32'd0);

    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      locked     = vt[i].lk;
      clear_lost = vt[i].clr;
      step(vt[i].cyc);
      chk_all($sformatf("vec%0d", i), vt[i].rst, vt[i].ce, vt[i].lost, vt[i].st);
    end

    // One-cycle lock drop in RUN, then relock
    locked = 1'b0; step(1);                                  // 108
    locked = 1'b1; step(1);                                  // 109
    chk_all("drop_109", 1'b1, 1'b0, 1'b0, 2'd2);
    step(1);                                                 // 110
    chk_all("drop_110", 1'b0, 1'b0, 1'b1, 2'd0);
    step(3);                                                 // 113
    chk("relock_113.state", 32'(state_o), 32'd0);
    step(1);                                                 // 114
    chk("relock_114.state", 32'(state_o), 32'd1);
    step(15);                                                // 129
    chk_all("relock_129", 1'b0, 1'b0, 1'b1, 2'd1);
    step(1);                                                 // 130
    chk_all("relock_130", 1'b1, 1'b0, 1'b1, 2'd2);

    // clear_lost alone, then coincident with a lock loss
    clear_lost = 1'b1; step(1);                              // 131
    chk("clr_131.lost", 32'(lock_lost), 32'd0);
    clear_lost = 1'b0; locked = 1'b0; step(2);               // 133
    chk_all("loss_133", 1'b1, 1'b0, 1'b0, 2'd2);
    clear_lost = 1'b1; step(1);                              // 134
    chk_all("loss_clr_134", 1'b0, 1'b0, 1'b1, 2'd0);
    clear_lost = 1'b0; step(1);                              // 135
    chk("sticky_135.lost", 32'(lock_lost), 32'd1);
    clear_lost = 1'b1; step(1);                              // 136
    chk("clr_136.lost", 32'(lock_lost), 32'd0);
    clear_lost = 1'b0;

    // Glitch 1,1,1,0,1... in WAIT_LOCK restarts the filter
    locked = 1'b1; step(3);                                  // 139
    locked = 1'b0; step(1);                                  // 140
    locked = 1'b1; step(1);                                  // 141
    chk("glitch_141.state", 32'(state_o), 32'd0);
    step(1);                                                 // 142
    chk("glitch_142.state", 32'(state_o), 32'd0);
    step(3);                                                 // 145
    chk("glitch_145.state", 32'(state_o), 32'd0);
    step(1);                                                 // 146
    chk("glitch_146.state", 32'(state_o), 32'd1);

    // Lock drop in HOLD: back to WAIT_LOCK without setting lock_lost
    locked = 1'b0; step(1);                                  // 147
    locked = 1'b1; step(1);                                  // 148
    chk("hold_148.state", 32'(state_o), 32'd1);
    step(1);                                                 // 149
    chk_all("hold_drop_149", 1'b0, 1'b0, 1'b0, 2'd0);
    step(4);                                                 // 153
    chk("hold_153.state", 32'(state_o), 32'd1);
    step(15);                                                // 168
    chk_all("hold_168", 1'b0, 1'b0, 1'b0, 2'd1);
    step(1);                                                 // 169
    chk_all("run_169", 1'b1, 1'b0, 1'b0, 2'd2);
    step(33);                                                // 202
    chk("ce_202", 32'(cpu_ce), 32'd0);
    step(1);                                                 // 203
    chk("ce_203", 32'(cpu_ce), 32'd1);
    step(1);                                                 // 204
    chk_all("ce_204", 1'b1, 1'b0, 1'b0, 2'd2);
    chk("ce1_run_204.state", 32'(state_o1), 32'd2);
    chk("ce1_run_204.ce", 32'(cpu_ce1), 32'd1);

    // Async reset mid-RUN, no clock edge in between
    #2 reset_n = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 1'b0, 1'b0, 2'd0);
    chk("async_rst.ce1", 32'(cpu_ce1), 32'd0);
    chk("async_rst.rst1", 32'(cpu_reset_n1), 32'd0);
    step(2);
    chk_all("async_rst_hold", 1'b0, 1'b0, 1'b0, 2'd0);

    // CE_DIV=1 instance: cpu_ce high every cycle after HOLD entry
    @(negedge clk);
    reset_n = 1'b1;
    step(5);
    chk("ce1_e5.state", 32'(state_o1), 32'd0);
    step(1);
    chk("ce1_e6.state", 32'(state_o1), 32'd1);
    chk("ce1_e6.ce", 32'(cpu_ce1), 32'd0);
    for (int e = 7; e <= 26; e++) begin
      step(1);
      chk($sformatf("ce1_e%0d.ce", e), 32'(cpu_ce1), 32'd1);
      if (e == 22) chk("relat_e22.rst", 32'(cpu_reset_n), 32'd1);
      if (e == 21) chk("relat_e21.rst", 32'(cpu_reset_n), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
